// File: rtl/pmem_arbiter_pkg.sv
// Shared types and widths for the physical-memory arbiter between the I-cache and
// D-cache miss paths and the cacheline adaptor.
package pmem_arbiter_pkg;

  localparam int LINE_WIDTH = 256;
  localparam int ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SERVE_I,
    ARB_SERVE_D
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } arb_grant_t;

endpackage

// File: rtl/pmem_arbiter_if.sv
// Bundles the I-cache, D-cache and cacheline-adaptor sides of the arbiter.
// master = arbiter view (drives the adaptor and the cache responses); slave = environment view.
interface pmem_arbiter_if;
  import pmem_arbiter_pkg::*;

  logic                  i_pmem_read;
  logic [ADDR_WIDTH-1:0] i_pmem_address;
  logic [LINE_WIDTH-1:0] i_pmem_rdata;
  logic                  i_pmem_resp;

  logic                  d_pmem_read;
  logic                  d_pmem_write;
  logic [ADDR_WIDTH-1:0] d_pmem_address;
  logic [LINE_WIDTH-1:0] d_pmem_wdata;
  logic [LINE_WIDTH-1:0] d_pmem_rdata;
  logic                  d_pmem_resp;

  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic [LINE_WIDTH-1:0] mem_rdata;
  logic                  mem_resp;

  modport master (
    input  i_pmem_read, i_pmem_address,
    output i_pmem_rdata, i_pmem_resp,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output d_pmem_rdata, d_pmem_resp,
    output mem_read, mem_write, mem_address, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport slave (
    output i_pmem_read, i_pmem_address,
    input  i_pmem_rdata, i_pmem_resp,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  d_pmem_rdata, d_pmem_resp,
    input  mem_read, mem_write, mem_address, mem_wdata,
    output mem_rdata, mem_resp
  );

endinterface

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter giving one cache-line transaction at a time to the I- or D-cache.
// Grant in IDLE -> registered mem op next cycle, held until mem_resp; resp forwarded same cycle, one idle bubble after.
module pmem_arbiter
  import pmem_arbiter_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  pmem_arbiter_if.master bus
);

  arb_state_t            state_q, state_d;
  arb_grant_t            last_grant_q, last_grant_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [LINE_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic       req_i;
  logic       req_d;
  logic       pick_vld;
  arb_grant_t pick;

  // On a tie the side that was not granted last wins, so neither cache can starve.
  always_comb begin
    req_i    = bus.i_pmem_read;
    req_d    = bus.d_pmem_read | bus.d_pmem_write;
    pick_vld = req_i | req_d;
    pick     = GRANT_I;
    if (req_i && req_d) begin
      pick = (last_grant_q == GRANT_I) ? GRANT_D : GRANT_I;
    end else if (req_d) begin
      pick = GRANT_D;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_vld) begin
          last_grant_d = pick;
          if (pick == GRANT_I) begin
            state_d       = ARB_SERVE_I;
            mem_read_d    = 1'b1;
            mem_write_d   = 1'b0;
            mem_address_d = bus.i_pmem_address;
          end else begin
            state_d       = ARB_SERVE_D;
            // A writeback wins over a fill if the D-cache ever raises both.
            mem_write_d   = bus.d_pmem_write;
            mem_read_d    = bus.d_pmem_read & ~bus.d_pmem_write;
            mem_address_d = bus.d_pmem_address;
            mem_wdata_d   = bus.d_pmem_wdata;
          end
        end
      end
      ARB_SERVE_I, ARB_SERVE_D: begin
        if (bus.mem_resp) begin
          state_d     = ARB_IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      default: begin
        state_d     = ARB_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      last_grant_q  <= GRANT_I;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign bus.mem_read     = mem_read_q;
  assign bus.mem_write    = mem_write_q;
  assign bus.mem_address  = mem_address_q;
  assign bus.mem_wdata    = mem_wdata_q;

  // Line data goes to both caches; only the owner's resp qualifies it.
  assign bus.i_pmem_rdata = bus.mem_rdata;
  assign bus.d_pmem_rdata = bus.mem_rdata;
  assign bus.i_pmem_resp  = bus.mem_resp & (state_q == ARB_SERVE_I);
  assign bus.d_pmem_resp  = bus.mem_resp & (state_q == ARB_SERVE_D);

  d_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(bus.d_pmem_read && bus.d_pmem_write))
    else $error("d_pmem_read and d_pmem_write asserted together");

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed and random stimulus for pmem_arbiter, checked every cycle against a
// transaction-level model of the grant rules, plus scenario-level counters.
module tb_pmem_arbiter;
  import pmem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pmem_arbiter_if bus ();

  pmem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [ADDR_WIDTH-1:0] addr;
    logic [LINE_WIDTH-1:0] wdata;
    logic                  wr;
  } req_t;

  int n_checks = 0;
  int n_fail   = 0;

  // requesters: pending queues, current request, one-cycle gap after a resp
  req_t i_q[$];
  req_t d_q[$];
  req_t i_cur;
  req_t d_cur;
  bit   i_act, d_act, i_gap, d_gap;

  // adaptor: latencies for successive transactions (random when empty)
  int lat_q[$];
  bit ad_busy;
  int ad_cnt;

  // reference model: owner 0 = none, 1 = I, 2 = D; last = 1 (I) or 2 (D)
  int                    own;
  int                    last;
  logic                  e_rd, e_wr;
  logic [ADDR_WIDTH-1:0] e_addr;
  logic [LINE_WIDTH-1:0] e_wdata;
  int                    grant_log[$];
  int                    rd_cycles, wr_cycles, i_resps, d_resps;

  task automatic chk(input string tag, input logic [LINE_WIDTH-1:0] obs,
                     input logic [LINE_WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_WIDTH-1:0] rand_line();
    logic [LINE_WIDTH-1:0] v;
    for (int k = 0; k < LINE_WIDTH / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic req_t mk(input logic [ADDR_WIDTH-1:0] a,
                              input logic [LINE_WIDTH-1:0] w, input logic wr);
    req_t r;
    r.addr  = a;
    r.wdata = w;
    r.wr    = wr;
    return r;
  endfunction

  task automatic clear_counts();
    rd_cycles = 0;
    wr_cycles = 0;
    i_resps   = 0;
    d_resps   = 0;
    grant_log.delete();
  endtask

  // One clock: drive this cycle's inputs, check outputs, advance the model.
  task automatic cycle(input bit do_rst = 1'b0, input bit stray = 1'b0);
    logic req_i, req_d, x_i, x_d;
    int   pick;
    @(posedge clk);
    #1;
    if (do_rst) begin
      i_act = 1'b0;
      d_act = 1'b0;
    end
    if (i_gap) i_gap = 1'b0;
    else if (!i_act && i_q.size() > 0) begin i_cur = i_q.pop_front(); i_act = 1'b1; end
    if (d_gap) d_gap = 1'b0;
    else if (!d_act && d_q.size() > 0) begin d_cur = d_q.pop_front(); d_act = 1'b1; end
    bus.i_pmem_read    = i_act;
    bus.i_pmem_address = i_act ? i_cur.addr : '0;
    bus.d_pmem_read    = d_act && !d_cur.wr;
    bus.d_pmem_write   = d_act && d_cur.wr;
    bus.d_pmem_address = d_act ? d_cur.addr : '0;
    bus.d_pmem_wdata   = d_act ? d_cur.wdata : '0;

    bus.mem_resp  = 1'b0;
    bus.mem_rdata = rand_line();
    if (do_rst) ad_busy = 1'b0;
    else if (bus.mem_read || bus.mem_write) begin
      if (!ad_busy) begin
        ad_busy = 1'b1;
        ad_cnt  = (lat_q.size() > 0) ? lat_q.pop_front() : int'($urandom_range(1, 5));
      end
      if (ad_cnt <= 1) begin
        bus.mem_resp = 1'b1;
        ad_busy      = 1'b0;
      end else ad_cnt--;
    end
    if (stray) bus.mem_resp = 1'b1;
    rst = do_rst;
    #1;

    x_i = bus.mem_resp && (own == 1);
    x_d = bus.mem_resp && (own == 2);
    chk("mem_read", bus.mem_read, e_rd);
    chk("mem_write", bus.mem_write, e_wr);
    chk("mem_address", bus.mem_address, e_addr);
    chk("mem_wdata", bus.mem_wdata, e_wdata);
    chk("i_pmem_resp", bus.i_pmem_resp, x_i);
    chk("d_pmem_resp", bus.d_pmem_resp, x_d);
    chk("i_pmem_rdata", bus.i_pmem_rdata, bus.mem_rdata);
    chk("d_pmem_rdata", bus.d_pmem_rdata, bus.mem_rdata);
    rd_cycles += int'(bus.mem_read);
    wr_cycles += int'(bus.mem_write);

    if (do_rst) begin
      own = 0; last = 1; e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wdata = '0;
    end else if (own == 0) begin
      req_i = bus.i_pmem_read;
      req_d = bus.d_pmem_read || bus.d_pmem_write;
      pick  = 0;
      if (req_i && req_d) pick = (last == 1) ? 2 : 1;
      else if (req_i)     pick = 1;
      else if (req_d)     pick = 2;
      if (pick == 1) begin
        e_rd = 1'b1; e_wr = 1'b0; e_addr = bus.i_pmem_address;
      end else if (pick == 2) begin
        e_wr    = bus.d_pmem_write;
        e_rd    = bus.d_pmem_read && !bus.d_pmem_write;
        e_addr  = bus.d_pmem_address;
        e_wdata = bus.d_pmem_wdata;
      end
      if (pick != 0) begin
        own  = pick;
        last = pick;
        grant_log.push_back(pick);
      end
    end else if (bus.mem_resp) begin
      own = 0; e_rd = 1'b0; e_wr = 1'b0;
    end

    if (x_i) begin i_act = 1'b0; i_gap = 1'b1; i_resps++; end
    if (x_d) begin d_act = 1'b0; d_gap = 1'b1; d_resps++; end
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int n = 0;
    while ((i_q.size() > 0 || d_q.size() > 0 || i_act || d_act || own != 0) && n < budget) begin
      cycle();
      n++;
    end
    chk({tag, " finished within budget"}, LINE_WIDTH'(n < budget), LINE_WIDTH'(1));
  endtask

  initial begin
    logic [LINE_WIDTH-1:0] a5;
    a5 = {32{8'hA5}};
    rst = 1'b1;
    bus.i_pmem_read = 1'b0; bus.i_pmem_address = '0;
    bus.d_pmem_read = 1'b0; bus.d_pmem_write = 1'b0;
    bus.d_pmem_address = '0; bus.d_pmem_wdata = '0;
    bus.mem_rdata = '0; bus.mem_resp = 1'b0;
    i_act = 0; d_act = 0; i_gap = 0; d_gap = 0; ad_busy = 0; ad_cnt = 0;
    own = 0; last = 1; e_rd = 0; e_wr = 0; e_addr = '0; e_wdata = '0;
    clear_counts();
    repeat (2) @(posedge clk);

    // reset state
    cycle(1'b1);
    cycle(1'b1);
    chk("reset mem_read", bus.mem_read, 0);
    chk("reset i_pmem_resp", bus.i_pmem_resp, 0);

    // I read, adaptor answers in the 4th cycle of mem_read
    clear_counts();
    i_q.push_back(mk(32'h0000_0060, '0, 1'b0));
    lat_q.push_back(4);
    run_until_done("i read", 50);
    chk("i read mem_read cycles", rd_cycles, 4);
    chk("i read i resps", i_resps, 1);
    chk("i read d resps", d_resps, 0);

    // D writeback
    clear_counts();
    d_q.push_back(mk(32'h0000_1000, a5, 1'b1));
    lat_q.push_back(3);
    run_until_done("d write", 50);
    chk("d write mem_write cycles", wr_cycles, 3);
    chk("d write mem_read cycles", rd_cycles, 0);
    chk("d write d resps", d_resps, 1);
    chk("d write i resps", i_resps, 0);

    // simultaneous requests after reset: D first, then strict alternation
    cycle(1'b1);
    clear_counts();
    for (int k = 0; k < 4; k++) begin
      d_q.push_back(mk(32'h0000_2000 + 32'(k * 256), '0, 1'b0));
      i_q.push_back(mk(32'h0000_0040 + 32'(k * 256), '0, 1'b0));
      lat_q.push_back(2);
      lat_q.push_back(2);
    end
    run_until_done("tie rounds", 200);
    chk("tie rounds grant count", grant_log.size(), 8);
    for (int k = 0; k < 8; k++) chk("tie rounds grant order", grant_log[k], (k % 2 == 0) ? 2 : 1);

    // D arrives while I is being served
    clear_counts();
    i_q.push_back(mk(32'h0000_0080, '0, 1'b0));
    lat_q.push_back(6);
    lat_q.push_back(2);
    cycle();
    cycle();
    d_q.push_back(mk(32'h0000_4000, '0, 1'b0));
    run_until_done("d during i", 100);
    chk("d during i grant count", grant_log.size(), 2);
    chk("d during i first grant", grant_log[0], 1);
    chk("d during i second grant", grant_log[1], 2);

    // reset two cycles into a D writeback, then a late adaptor resp
    cycle();
    clear_counts();
    d_q.push_back(mk(32'h0000_3000, rand_line(), 1'b1));
    lat_q.push_back(10);
    cycle();
    cycle();
    cycle();
    cycle(1'b1);
    cycle();
    chk("rst mid txn mem_write", bus.mem_write, 0);
    cycle(1'b0, 1'b1);
    chk("late resp d_pmem_resp", bus.d_pmem_resp, 0);
    chk("late resp i_pmem_resp", bus.i_pmem_resp, 0);
    chk("rst mid txn d resps", d_resps, 0);

    // stray adaptor resp with nothing pending
    cycle();
    cycle(1'b0, 1'b1);
    chk("stray resp i_pmem_resp", bus.i_pmem_resp, 0);
    chk("stray resp d_pmem_resp", bus.d_pmem_resp, 0);
    cycle();

    // random traffic
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 1) == 1)
        i_q.push_back(mk($urandom() & 32'hFFFF_FFE0, '0, 1'b0));
      if ($urandom_range(0, 1) == 1)
        d_q.push_back(mk($urandom() & 32'hFFFF_FFE0, rand_line(), 1'($urandom_range(0, 1))));
      repeat ($urandom_range(1, 6)) cycle();
    end
    run_until_done("random", 3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
